// File: rtl/fp_mul_arbiter_if.sv
// Requester-side bus of the shared FP multiplier arbiter.
//   req_valid_i / req_ready_o : per-requester operand handshake
//   req_a_i / req_b_i         : packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid_o / rsp_ready_i : per-requester result handshake (FWFT FIFO head)
//   rsp_data_o                : packed FIFO heads, same packing as operands
// The slave modport is the arbiter; the master modport is the requester side.
interface fp_mul_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 24
);
  logic [NUM_REQ-1:0]       req_valid_i;
  logic [NUM_REQ-1:0]       req_ready_o;
  logic [NUM_REQ*WIDTH-1:0] req_a_i;
  logic [NUM_REQ*WIDTH-1:0] req_b_i;
  logic [NUM_REQ-1:0]       rsp_valid_o;
  logic [NUM_REQ-1:0]       rsp_ready_i;
  logic [NUM_REQ*WIDTH-1:0] rsp_data_o;

  modport slave (
    input  req_valid_i, req_a_i, req_b_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_data_o
  );

  modport master (
    output req_valid_i, req_a_i, req_b_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o
  );
endinterface

// File: rtl/fp_mul_arbiter.sv
// Shares one fixed-latency pipelined FP multiplier between NUM_REQ requesters.
// Round-robin issue (one op per cycle), a tag pipeline that follows each op
// through the multiplier, and per-requester response FIFOs guarded by credits
// so a stalled consumer only ever blocks itself.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   req_if (slave)        : requester operand/response bus (see fp_mul_arbiter_if)
//   mul_valid_o/a_o/b_o   : registered operands to the multiplier
//   mul_result_i          : multiplier result, MUL_LATENCY cycles after mul_valid_o
//   busy_o                : registered; op in the tag pipeline or any FIFO non-empty

// Invariant checks for the credit / FIFO bookkeeping.
module fp_mul_arbiter_chk #(
  parameter int NUM_REQ   = 4,
  parameter int CW        = 2,
  parameter int RSP_DEPTH = 2
) (
  input logic                  clk,
  input logic                  rst,
  input logic [NUM_REQ*CW-1:0] credit_i,
  input logic [NUM_REQ-1:0]    grant_i,
  input logic [NUM_REQ-1:0]    wr_en_i,
  input logic [NUM_REQ-1:0]    full_i
);
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_chk
    a_credit_max: assert property (@(posedge clk) disable iff (rst)
      credit_i[i*CW +: CW] <= CW'(RSP_DEPTH))
      else $error("credit above depth for requester %0d", i);
    a_credit_nonneg: assert property (@(posedge clk) disable iff (rst)
      grant_i[i] |-> (credit_i[i*CW +: CW] != '0))
      else $error("grant without credit for requester %0d", i);
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      wr_en_i[i] |-> !full_i[i])
      else $error("response FIFO overflow for requester %0d", i);
  end
  a_onehot_grant: assert property (@(posedge clk) disable iff (rst) $onehot0(grant_i))
    else $error("grant vector not one-hot");
endmodule

module fp_mul_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = 24,
  parameter int MUL_LATENCY = 2,
  parameter int RSP_DEPTH   = 2
) (
  input  logic               clk,
  input  logic               rst,
  fp_mul_arbiter_if.slave    req_if,
  output logic               mul_valid_o,
  output logic [WIDTH-1:0]   mul_a_o,
  output logic [WIDTH-1:0]   mul_b_o,
  input  logic [WIDTH-1:0]   mul_result_i,
  output logic               busy_o
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW  = $clog2(RSP_DEPTH + 1);
  localparam int PW  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(RSP_DEPTH);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);

  logic                   mul_valid_q;
  logic [WIDTH-1:0]       mul_a_q, mul_b_q;
  logic [IDW-1:0]         issue_id_q, rr_ptr_q;
  logic [MUL_LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [IDW-1:0]         tag_id_q [MUL_LATENCY];
  logic [IDW-1:0]         tag_id_d [MUL_LATENCY];
  logic [CW-1:0]          credit_q [NUM_REQ];
  logic [CW-1:0]          credit_d [NUM_REQ];
  logic [CW-1:0]          count_q  [NUM_REQ];
  logic [CW-1:0]          count_d  [NUM_REQ];
  logic [PW-1:0]          rd_ptr_q [NUM_REQ];
  logic [PW-1:0]          wr_ptr_q [NUM_REQ];
  logic [WIDTH-1:0]       mem_q    [NUM_REQ][RSP_DEPTH];
  logic                   busy_q, busy_d;

  logic [NUM_REQ-1:0]     elig_s, grant_s, wr_en_s, pop_s, full_s;
  logic                   grant_vld_s, hit_s;
  logic [IDW-1:0]         grant_id_s, cand_s;
  logic [NUM_REQ*CW-1:0]  credit_flat_s;

  // Circular pointer advance that also works for non-power-of-two wrap points.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    logic [PW-1:0] r;
    if (p == PW'(RSP_DEPTH - 1)) r = '0;
    else                         r = p + PW'(1);
    return r;
  endfunction

  // A requester may only compete while it still owns a free result slot.
  always_comb begin
    elig_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig_s[i] = req_if.req_valid_i[i] & (credit_q[i] != '0);
    end
  end

  // Round-robin scan starting just after the last granted requester.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_id_s  = rr_ptr_q;
    cand_s      = '0;
    hit_s       = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_s      = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
      hit_s       = ~grant_vld_s & elig_s[cand_s];
      grant_id_s  = hit_s ? cand_s : grant_id_s;
      grant_vld_s = grant_vld_s | hit_s;
    end
    grant_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_s[i] = grant_vld_s & (grant_id_s == IDW'(i));
    end
  end

  assign req_if.req_ready_o = grant_s;
  assign mul_valid_o        = mul_valid_q;
  assign mul_a_o            = mul_a_q;
  assign mul_b_o            = mul_b_q;
  assign busy_o             = busy_q;

  // FIFO status, first-word-fall-through heads and write/pop strobes.
  always_comb begin
    req_if.rsp_valid_o = '0;
    req_if.rsp_data_o  = '0;
    full_s             = '0;
    wr_en_s            = '0;
    pop_s              = '0;
    credit_flat_s      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_if.rsp_valid_o[i]              = (count_q[i] != '0);
      req_if.rsp_data_o[i*WIDTH +: WIDTH] = (count_q[i] != '0) ? mem_q[i][rd_ptr_q[i]] : '0;
      full_s[i]   = (count_q[i] == DEPTH_C);
      wr_en_s[i]  = tag_vld_q[MUL_LATENCY-1] & (tag_id_q[MUL_LATENCY-1] == IDW'(i));
      pop_s[i]    = (count_q[i] != '0) & req_if.rsp_ready_i[i];
      credit_flat_s[i*CW +: CW] = credit_q[i];
    end
  end

  // Next state of tag pipeline, credits, occupancy and busy.
  always_comb begin
    tag_vld_d[0] = mul_valid_q;
    tag_id_d[0]  = issue_id_q;
    for (int k = 1; k < MUL_LATENCY; k++) begin
      tag_vld_d[k] = tag_vld_q[k-1];
      tag_id_d[k]  = tag_id_q[k-1];
    end
    busy_d = |tag_vld_d;
    for (int i = 0; i < NUM_REQ; i++) begin
      // Grant and pop together cancel out.
      case ({grant_s[i], pop_s[i]})
        2'b10:   credit_d[i] = credit_q[i] - CW'(1);
        2'b01:   credit_d[i] = credit_q[i] + CW'(1);
        default: credit_d[i] = credit_q[i];
      endcase
      case ({wr_en_s[i], pop_s[i]})
        2'b10:   count_d[i] = count_q[i] + CW'(1);
        2'b01:   count_d[i] = count_q[i] - CW'(1);
        default: count_d[i] = count_q[i];
      endcase
      busy_d = busy_d | (count_d[i] != '0);
    end
  end

  // All state: issue registers, tag pipeline, credits and response FIFOs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_valid_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      issue_id_q  <= '0;
      rr_ptr_q    <= LAST_ID;
      tag_vld_q   <= '0;
      busy_q      <= 1'b0;
      for (int k = 0; k < MUL_LATENCY; k++) tag_id_q[k] <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        credit_q[i] <= DEPTH_C;
        count_q[i]  <= '0;
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        for (int j = 0; j < RSP_DEPTH; j++) mem_q[i][j] <= '0;
      end
    end else begin
      mul_valid_q <= grant_vld_s;
      if (grant_vld_s) begin
        mul_a_q    <= req_if.req_a_i[int'(grant_id_s)*WIDTH +: WIDTH];
        mul_b_q    <= req_if.req_b_i[int'(grant_id_s)*WIDTH +: WIDTH];
        issue_id_q <= grant_id_s;
        rr_ptr_q   <= grant_id_s;
      end else begin
        mul_a_q    <= mul_a_q;
        mul_b_q    <= mul_b_q;
        issue_id_q <= issue_id_q;
        rr_ptr_q   <= rr_ptr_q;
      end
      tag_vld_q <= tag_vld_d;
      tag_id_q  <= tag_id_d;
      busy_q    <= busy_d;
      for (int i = 0; i < NUM_REQ; i++) begin
        credit_q[i] <= credit_d[i];
        count_q[i]  <= count_d[i];
        if (wr_en_s[i]) begin
          mem_q[i][wr_ptr_q[i]] <= mul_result_i;
          wr_ptr_q[i]           <= ptr_inc(wr_ptr_q[i]);
        end
        if (pop_s[i]) begin
          rd_ptr_q[i] <= ptr_inc(rd_ptr_q[i]);
        end
      end
    end
  end

  fp_mul_arbiter_chk #(
    .NUM_REQ  (NUM_REQ),
    .CW       (CW),
    .RSP_DEPTH(RSP_DEPTH)
  ) u_chk (
    .clk     (clk),
    .rst     (rst),
    .credit_i(credit_flat_s),
    .grant_i (grant_s),
    .wr_en_i (wr_en_s),
    .full_i  (full_s)
  );
endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed, table-driven bench for fp_mul_arbiter with a behavioural
// 2-stage saturating multiplier and a per-requester result scoreboard.
module tb_fp_mul_arbiter;
  localparam int N = 4;
  localparam int W = 24;

  logic         clk = 1'b0;
  logic         rst;
  logic         mul_valid_o;
  logic [W-1:0] mul_a_o, mul_b_o, mul_result_i;
  logic         busy_o;

  fp_mul_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

  fp_mul_arbiter #(.NUM_REQ(N), .WIDTH(W), .MUL_LATENCY(2), .RSP_DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_if      (bus),
    .mul_valid_o (mul_valid_o),
    .mul_a_o     (mul_a_o),
    .mul_b_o     (mul_b_o),
    .mul_result_i(mul_result_i),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  // Reference multiply: truncating, saturating to 0x7F8000, zero for exp==0.
  function automatic logic [23:0] fmul(input logic [23:0] a, input logic [23:0] b);
    logic        s;
    logic [31:0] p;
    logic [14:0] m;
    int          e;
    s = a[23] ^ b[23];
    if (a[22:15] == 8'd0 || b[22:15] == 8'd0) return 24'h000000;
    p = {16'h0000, 1'b1, a[14:0]} * {16'h0000, 1'b1, b[14:0]};
    e = int'(a[22:15]) + int'(b[22:15]) - 127;
    if (p[31]) begin m = p[30:16]; e = e + 1; end
    else       begin m = p[29:15]; end
    if (e >= 255) return {s, 8'hFF, 15'h0000};
    if (e <= 0)   return 24'h000000;
    return {s, e[7:0], m};
  endfunction

  logic [W-1:0] mp0, mp1;
  always @(posedge clk) begin
    mp0 <= mul_valid_o ? fmul(mul_a_o, mul_b_o) : 24'h000000;
    mp1 <= mp0;
  end
  assign mul_result_i = mp1;

  int           n_chk  = 0;
  int           n_fail = 0;
  logic [W-1:0] sb [N][$];
  int           issued [N];

  typedef struct {
    int           r;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;
  vec_t vt [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_a_i[i*W +: W] = a;
    bus.req_b_i[i*W +: W] = b;
  endtask

  // One clock: score pops and handshakes just before the edge, return at edge+1.
  task automatic step();
    logic [W-1:0] e;
    #1;
    for (int i = 0; i < N; i++) begin
      if (bus.rsp_valid_o[i] && bus.rsp_ready_i[i]) begin
        if (sb[i].size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL rsp_unexpected[%0d]: got data %h, required no response", i, bus.rsp_data_o[i*W +: W]);
        end else begin
          e = sb[i].pop_front();
          chk($sformatf("rsp_data[%0d]", i), 32'(bus.rsp_data_o[i*W +: W]), 32'(e));
        end
      end
      if (bus.req_valid_i[i] && bus.req_ready_o[i]) begin
        sb[i].push_back(fmul(bus.req_a_i[i*W +: W], bus.req_b_i[i*W +: W]));
        issued[i]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_issued();
    for (int i = 0; i < N; i++) issued[i] = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{0, 24'h3FC000, 24'h400000, 24'h404000};
    vt[1] = '{1, 24'h7F0000, 24'h7F0000, 24'h7F8000};
    vt[2] = '{2, 24'h000000, 24'h3FC000, 24'h000000};
    vt[3] = '{0, 24'hBFC000, 24'h400000, 24'hC04000};
    vt[4] = '{3, 24'h400000, 24'h400000, 24'h408000};

    rst             = 1'b1;
    bus.req_valid_i = '0;
    bus.rsp_ready_i = '1;
    bus.req_a_i     = '0;
    bus.req_b_i     = '0;
    clear_issued();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_mul_valid", 32'(mul_valid_o), 32'd0);
    chk("reset_mul_a", 32'(mul_a_o), 32'd0);
    chk("reset_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    chk("reset_rsp_data", bus.rsp_data_o[31:0], 32'd0);
    chk("reset_busy", 32'(busy_o), 32'd0);
    rst = 1'b0;
    step();

    // Single operations with exact latency through each requester.
    for (int v = 0; v < 5; v++) begin
      set_op(vt[v].r, vt[v].a, vt[v].b);
      bus.req_valid_i = 4'(32'd1 << vt[v].r);
      #1;
      chk("single_ready", 32'(bus.req_ready_o), 32'd1 << vt[v].r);
      step();
      bus.req_valid_i = '0;
      chk("single_mul_valid", 32'(mul_valid_o), 32'd1);
      chk("single_mul_a", 32'(mul_a_o), 32'(vt[v].a));
      chk("single_mul_b", 32'(mul_b_o), 32'(vt[v].b));
      step();
      chk("single_early1", 32'(bus.rsp_valid_o), 32'd0);
      step();
      chk("single_early2", 32'(bus.rsp_valid_o), 32'd0);
      step();
      chk("single_rsp_valid", 32'(bus.rsp_valid_o), 32'd1 << vt[v].r);
      chk("single_rsp_data", 32'(bus.rsp_data_o[vt[v].r*W +: W]), 32'(vt[v].exp));
      chk("single_busy_hi", 32'(busy_o), 32'd1);
      step();
      chk("single_rsp_gone", 32'(bus.rsp_valid_o), 32'd0);
      chk("single_busy_lo", 32'(busy_o), 32'd0);
    end

    // Round-robin with all requesters valid continuously.
    clear_issued();
    for (int i = 0; i < N; i++) set_op(i, {1'b0, 8'd127, 15'(i * 100)}, 24'h400000);
    bus.req_valid_i = '1;
    for (int k = 0; k < 16; k++) begin
      #1;
      chk("rr_grant", 32'(bus.req_ready_o), 32'd1 << (k % 4));
      step();
      chk("rr_mul_valid", 32'(mul_valid_o), 32'd1);
      set_op(k % 4, {1'b0, 8'd127, 15'(1000 + k * 7)}, 24'h400000);
    end
    bus.req_valid_i = '0;
    repeat (6) step();
    for (int i = 0; i < N; i++) begin
      chk("rr_count", 32'(issued[i]), 32'd4);
      chk("rr_drained", 32'(sb[i].size()), 32'd0);
    end

    // Credit stall on requester 2; others keep issuing every cycle.
    clear_issued();
    bus.rsp_ready_i = 4'b1011;
    bus.req_valid_i = '1;
    for (int k = 0; k < 20; k++) begin
      #1;
      chk("stall_throughput", 32'(|bus.req_ready_o), 32'd1);
      step();
      set_op(k % 4, {1'b0, 8'd128, 15'(2000 + k * 11)}, 24'h3FC000);
    end
    #1;
    chk("stall_grants2", 32'(issued[2]), 32'd2);
    chk("stall_ready2", 32'(bus.req_ready_o[2]), 32'd0);
    chk("stall_others", 32'(issued[0] + issued[1] + issued[3]), 32'd18);
    bus.rsp_ready_i = '1;
    repeat (8) step();
    chk("stall_resume", 32'(issued[2] > 2), 32'd1);
    bus.req_valid_i = '0;
    repeat (8) step();
    for (int i = 0; i < N; i++) chk("stall_drained", 32'(sb[i].size()), 32'd0);

    // Pop and valid in the same cycle with zero credit and a full FIFO.
    bus.rsp_ready_i = 4'b1101;
    set_op(1, 24'h3FC000, 24'h3FC000);
    bus.req_valid_i = 4'b0010;
    step();
    set_op(1, 24'h404000, 24'h400000);
    step();
    #1;
    chk("pg_no_credit", 32'(bus.req_ready_o), 32'd0);
    repeat (4) step();
    chk("pg_fifo_valid", 32'(bus.rsp_valid_o), 32'h2);
    bus.rsp_ready_i = 4'b1111;
    #1;
    chk("pg_nogrant", 32'(bus.req_ready_o), 32'd0);
    step();
    bus.rsp_ready_i = 4'b1101;
    #1;
    chk("pg_next_grant", 32'(bus.req_ready_o), 32'h2);
    step();
    bus.req_valid_i = '0;
    bus.rsp_ready_i = '1;
    repeat (8) step();
    chk("pg_drained", 32'(sb[1].size()), 32'd0);

    // Reset with 2 buffered results and 3 operations in flight.
    bus.rsp_ready_i = 4'b1110;
    set_op(0, 24'h3FC000, 24'h400000);
    bus.req_valid_i = 4'b0001;
    step();
    set_op(0, 24'h400000, 24'h400000);
    step();
    bus.req_valid_i = '0;
    repeat (4) step();
    chk("rm_buffered", 32'(bus.rsp_valid_o), 32'h1);
    bus.req_valid_i = 4'b1110;
    repeat (3) step();
    chk("rm_in_flight", 32'(busy_o), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rm_mul_valid", 32'(mul_valid_o), 32'd0);
    chk("rm_mul_a", 32'(mul_a_o), 32'd0);
    chk("rm_mul_b", 32'(mul_b_o), 32'd0);
    chk("rm_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    chk("rm_rsp_data", bus.rsp_data_o[31:0], 32'd0);
    chk("rm_busy", 32'(busy_o), 32'd0);
    for (int i = 0; i < N; i++) sb[i].delete();
    bus.req_valid_i = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.rsp_ready_i = '1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rm_no_stale", 32'(bus.rsp_valid_o), 32'd0);
    end
    bus.req_valid_i = '1;
    #1;
    chk("rm_first_grant", 32'(bus.req_ready_o), 32'h1);
    step();
    bus.req_valid_i = '0;
    repeat (6) step();
    for (int i = 0; i < N; i++) chk("rm_drained", 32'(sb[i].size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fp_mul_arbiter.md
Name: fp_mul_arbiter

Overview:
- Shares one pipelined FP multiplier (24-bit format: sign[23], exp[22:15] with bias 127, mantissa[14:0]) between NUM_REQ requesters.
- Round-robin issue, at most one operation per cycle.
- Tracks in-flight operations with a tag pipeline and routes each result to a per-requester response FIFO.
- Credit-based flow control: a stalled consumer never blocks other requesters and never loses a result.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 24, operand/result width.
- MUL_LATENCY, 2, cycles from mul_valid_o high to the matching mul_result_i valid (fixed multiplier pipeline depth).
- RSP_DEPTH, 2, entries per requester response FIFO (power of two, >=1).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req_valid_i  in  NUM_REQ  operand pair valid, per requester.
- req_ready_o  out  NUM_REQ  grant/accept, per requester.
- req_a_i  in  NUM_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b_i  in  NUM_REQ*WIDTH  operand B; same packing.
- mul_valid_o  out  1  operands valid to multiplier.
- mul_a_o  out  WIDTH  operand A to multiplier.
- mul_b_o  out  WIDTH  operand B to multiplier.
- mul_result_i  in  WIDTH  multiplier result; meaningful MUL_LATENCY cycles after mul_valid_o.
- rsp_valid_o  out  NUM_REQ  result available, per requester.
- rsp_ready_i  in  NUM_REQ  consumer pops result.
- rsp_data_o  out  NUM_REQ*WIDTH  FIFO head per requester.
- busy_o  out  1  any operation in flight or any FIFO non-empty.

Behaviour:
- Reset (async assert, sync deassert by the system):
  - mul_valid_o=0, mul_a_o=mul_b_o=0.
  - Tag pipeline cleared; all FIFOs empty, so rsp_valid_o=0 and rsp_data_o=0.
  - credit[i]=RSP_DEPTH; RR pointer=NUM_REQ-1, so requester 0 has first priority.
  - busy_o=0.
  - Reset mid-operation discards all in-flight and buffered results.
- Eligibility: requester i is eligible when req_valid_i[i]=1 and credit[i]>0.
- Grant (combinational):
  - Scan eligible requesters starting at pointer+1, wrapping modulo NUM_REQ; the first found is granted.
  - req_ready_o is one-hot or zero; req_ready_o[i] may depend on req_valid_i[i]. Requesters must not gate valid on ready.
- Handshake and issue:
  - Handshake occurs on a rising edge with req_valid_i[i]&req_ready_o[i].
  - On that edge: mul_a_o/mul_b_o register the granted operands, mul_valid_o<=1, pointer<=i.
  - With no grant: mul_valid_o<=0, operands hold, pointer holds.
- Tag pipeline:
  - MUL_LATENCY-stage shift register of {valid, id}, loaded from {mul_valid_o, issued id}.
  - When its last stage is valid, mul_result_i is written into FIFO[id] on that edge.
- Latency:
  - Handshake edge E0; mul_valid_o high in the cycle after E0.
  - Result written at edge E0+1+MUL_LATENCY; rsp_valid_o high after that edge.
  - Total is 1+MUL_LATENCY+1 cycles: 4 for the default.
- Credits:
  - credit[i] = RSP_DEPTH - FIFO occupancy - in-flight count for i.
  - Decrement on grant to i; increment on pop (rsp_valid_o[i]&rsp_ready_i[i]).
  - Grant and pop in the same cycle: credit unchanged.
  - Credit never exceeds RSP_DEPTH and never goes negative (assertion).
  - Consequently a FIFO write never finds the FIFO full (assertion).
- FIFO:
  - Per-requester circular buffer with wrapping read/write pointers.
  - Write and pop in the same cycle when full or empty are both legal.
  - Data is shown first-word-fall-through at rsp_data_o.
  - Results stay in issue order per requester.
- Backpressure: rsp_ready_i[i]=0 stalls only requester i, once its credits are exhausted. Other requesters keep full throughput of one issue per cycle.
- Data transparency: results pass unmodified. This includes the overflow pattern 0x7F8000 and zero (0x000000).
- busy_o: registered; high whenever any tag stage is valid or any FIFO is non-empty.

Test Plan:
- Single op: req 0 sends a=0x3FC000 (1.5), b=0x400000 (2.0); rsp_ready_i=all 1.
  - req_ready_o[0]=1 at once.
  - mul_a_o=0x3FC000 one cycle later.
  - rsp_valid_o[0]=1 with rsp_data_o[0]=0x404000 (3.0) exactly 4 cycles after the handshake, for one cycle.
  - busy_o returns to 0.
- Round-robin: all 4 requesters valid continuously.
  - Grants follow 0,1,2,3,0,1,...
  - mul_valid_o held at 1.
  - Each requester's results are in order, and each receives 1 in 4 issues.
- Credit stall: rsp_ready_i[2]=0, all requesters valid.
  - Requester 2 is granted exactly RSP_DEPTH=2 times, then req_ready_o[2]=0.
  - Others keep issuing back-to-back.
  - Raise rsp_ready_i[2]: 2 results drain in order and issue to 2 resumes.
- Simultaneous pop and grant: requester 1 with credit=0, FIFO full, popping and valid in the same cycle.
  - No grant that cycle (credit was 0); grant the next cycle.
  - FIFO never overflows (assertion clean).
- Special values: a=0x7F0000, b=0x7F0000, with the multiplier saturating.
  - rsp_data_o=0x7F8000 passed unchanged.
  - a=0x000000 gives result 0x000000.
- Reset mid-flight: assert rst with 3 ops in flight and 2 buffered results.
  - All outputs at reset values immediately.
  - No stale rsp_valid_o after deassert.
  - The first grant after deassert goes to requester 0.
